// File: rtl/demux_chan_deserializer.sv
// Rebuilds four serial bit streams from a 1-to-4 demux into WIDTH-bit words, one holding slot per channel.
// A completed word can appear one cycle later; the output holds under back-pressure; a word landing on a full slot is dropped.
module demux_chan_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [1:0]       sel,
  input  logic [3:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_chan,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       overflow,
  output logic             proto_err,
  input  logic             clear_flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] sreg      [4];
  logic [CW-1:0]    cnt       [4];
  logic [WIDTH-1:0] hold      [4];
  logic [3:0]       hold_full;
  logic [1:0]       ptr;

  logic             cap_bit;
  logic [WIDTH-1:0] cap_word;
  logic             cap_done;
  logic             bad_sel;
  logic             load_en;
  logic             grant_vld;
  logic [1:0]       grant_ch;
  logic [1:0]       idx;
  logic [3:0]       drain;
  logic [3:0]       hf_nxt;
  logic [3:0]       ovf_set;
  logic             hold_we;

  // Any active demux line counts as a 1; the channel always comes from sel.
  always_comb begin
    cap_bit  = |y;
    cap_word = {sreg[sel], cap_bit};
    cap_done = bit_valid && (cnt[sel] == LAST);
    bad_sel  = bit_valid && (y != 4'b0000) && (y != (4'b0001 << sel));
  end

  // Round-robin pick: lowest offset from ptr wins, so scan offsets high to low.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = ptr;
    idx       = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (hold_full[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign load_en = !out_valid || out_ready;

  // A slot drained on this edge may be refilled by a word completing on the same edge.
  always_comb begin
    drain   = (load_en && grant_vld) ? (4'b0001 << grant_ch) : 4'b0000;
    hf_nxt  = hold_full & ~drain;
    ovf_set = 4'b0000;
    hold_we = 1'b0;
    if (cap_done) begin
      if (!hold_full[sel] || drain[sel]) begin
        hf_nxt[sel] = 1'b1;
        hold_we     = 1'b1;
      end else begin
        ovf_set[sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        sreg[k] <= '0;
        cnt[k]  <= '0;
        hold[k] <= '0;
      end
      hold_full <= 4'b0000;
      ptr       <= 2'd0;
    end else begin
      if (bit_valid) begin
        sreg[sel] <= cap_word[WIDTH-2:0];
        cnt[sel]  <= cap_done ? '0 : cnt[sel] + CW'(1);
      end
      if (hold_we) begin
        hold[sel] <= cap_word;
      end
      hold_full <= hf_nxt;
      if (load_en && grant_vld) begin
        ptr <= grant_ch + 2'd1;
      end
    end
  end

  // Output register; data and channel stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_chan  <= 2'd0;
      out_data  <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_chan  <= grant_ch;
        out_data  <= hold[grant_ch];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 4'b0000;
      proto_err <= 1'b0;
    end else begin
      overflow  <= (clear_flags ? 4'b0000 : overflow) | ovf_set;
      proto_err <= (clear_flags ? 1'b0 : proto_err) | bad_sel;
    end
  end

endmodule

// File: tb/tb_demux_chan_deserializer.sv
// Directed bench for demux_chan_deserializer; delivered words are matched against a queue of expected {chan, data}.
module tb_demux_chan_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bit_valid;
  logic [1:0]   sel;
  logic [3:0]   y;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_chan;
  logic [W-1:0] out_data;
  logic [3:0]   overflow;
  logic         proto_err;
  logic         clear_flags;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb [$];

  demux_chan_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sel(sel), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_data(out_data), .overflow(overflow), .proto_err(proto_err),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every accepted transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", {out_chan, out_data});
      end
      if (sb.size() != 0) chk("sb_word", {22'b0, out_chan, out_data}, {22'b0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [1:0] s, input logic [3:0] yy);
    bit_valid = 1'b1;
    sel       = s;
    y         = yy;
    tick();
    bit_valid = 1'b0;
    y         = 4'b0000;
  endtask

  task automatic send_bit(input logic [1:0] ch, input logic b);
    send_raw(ch, b ? (4'b0001 << ch) : 4'b0000);
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [7:0] w, input bit push);
    if (push) sb.push_back({ch, w});
    for (int i = 7; i >= 0; i--) send_bit(ch, w[i]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] rr_seq [5];
    logic [1:0] rr2_seq [3];
    rst_n = 1'b0; bit_valid = 1'b0; sel = 2'd0; y = 4'b0000;
    out_ready = 1'b1; clear_flags = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_chan",  out_chan,  0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_proto_err", proto_err, 0);
    #9 rst_n = 1'b1;
    tick();

    // Channel 2 assembly: 1,0,1,1,0,0,1,0 -> B2
    send_word(2'd2, 8'hB2, 1);
    chk("c2_not_yet", out_valid, 0);
    tick();
    chk("c2_valid", out_valid, 1);
    chk("c2_chan",  out_chan,  2);
    chk("c2_data",  out_data,  8'hB2);
    chk("c2_ovf",   overflow,  0);
    chk("c2_perr",  proto_err, 0);
    tick();
    chk("c2_idle", out_valid, 0);

    // Interleaved ch0 ones and ch3 zeros
    sb.push_back({2'd0, 8'hFF});
    sb.push_back({2'd3, 8'h00});
    for (int i = 0; i < 8; i++) begin
      send_bit(2'd0, 1'b1);
      send_bit(2'd3, 1'b0);
    end
    drain("il_drain");
    tick();
    chk("il_idle", out_valid, 0);

    // Back-pressure: third word on ch1 is dropped
    out_ready = 1'b0;
    send_word(2'd1, 8'hA5, 1);
    send_word(2'd1, 8'h3C, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_chan",  out_chan,  1);
    chk("bp_hold1", out_data,  8'hA5);
    chk("bp_no_ovf", overflow, 0);
    send_word(2'd1, 8'h7E, 0);
    tick();
    chk("bp_hold2", out_data, 8'hA5);
    chk("bp_ovf",   overflow, 4'b0010);
    out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_idle", out_valid, 0);
    chk("bp_ovf_sticky", overflow, 4'b0010);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("bp_ovf_clr", overflow, 0);

    // Fairness: ch3 parked in output (ptr -> 0), then all four slots fill
    out_ready = 1'b0;
    send_word(2'd3, 8'h33, 1);
    send_word(2'd0, 8'h10, 1);
    send_word(2'd1, 8'h21, 1);
    send_word(2'd2, 8'h42, 1);
    send_word(2'd3, 8'h83, 1);
    out_ready = 1'b1;
    rr_seq = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_valid%0d", i), out_valid, 1);
      chk($sformatf("rr_chan%0d", i), out_chan, rr_seq[i]);
      tick();
    end
    chk("rr_idle", out_valid, 0);
    chk("rr_sb", sb.size(), 0);

    // ptr=1 after ch0 is granted; ch3 completes before ch2 but ch2 wins
    out_ready = 1'b0;
    sb.push_back({2'd0, 8'h5E});
    sb.push_back({2'd2, 8'h66});
    sb.push_back({2'd3, 8'h77});
    send_word(2'd0, 8'h5E, 0);
    send_word(2'd3, 8'h77, 0);
    send_word(2'd2, 8'h66, 0);
    out_ready = 1'b1;
    rr2_seq = '{2'd0, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr2_chan%0d", i), out_chan, rr2_seq[i]);
      tick();
    end
    chk("rr2_sb", sb.size(), 0);

    // Protocol error: sel=1 but y4-line... y=0100 counted as a 1 on ch1
    send_raw(2'd1, 4'b0100);
    chk("pe_set", proto_err, 1);
    sb.push_back({2'd1, 8'h80});
    for (int i = 0; i < 7; i++) send_bit(2'd1, 1'b0);
    drain("pe_drain");
    chk("pe_sticky", proto_err, 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("pe_clr", proto_err, 0);
    // set on the same edge as clear wins
    sb.push_back({2'd1, 8'hFF});
    clear_flags = 1'b1;
    send_raw(2'd1, 4'b0011);
    clear_flags = 1'b0;
    chk("pe_set_wins", proto_err, 1);
    for (int i = 0; i < 7; i++) send_bit(2'd1, 1'b1);
    drain("pe2_drain");
    chk("pe2_ovf", overflow, 0);

    // Async reset mid-word with a word held on the output
    out_ready = 1'b0;
    send_word(2'd2, 8'h5A, 0);
    tick();
    chk("ar_pre_valid", out_valid, 1);
    send_bit(2'd0, 1'b1);
    send_bit(2'd0, 1'b0);
    send_raw(2'd0, 4'b1111);
    send_bit(2'd0, 1'b0);
    send_bit(2'd0, 1'b1);
    chk("ar_pre_perr", proto_err, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_chan",  out_chan,  0);
    chk("ar_data",  out_data,  0);
    chk("ar_ovf",   overflow,  0);
    chk("ar_perr",  proto_err, 0);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_word(2'd0, 8'hC3, 1);
    drain("ar_drain");
    for (int i = 0; i < 3; i++) tick();
    chk("ar_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
